// File: rtl/uart_tx_arbiter.sv
// Message-granular arbiter sharing one UART transmitter between NREQ byte-stream requesters.
// Build option: define ARB_FIXED_PRIO_EN for lowest-index-wins selection instead of round-robin.
module uart_tx_arbiter #(
   parameter int NREQ           = 3,
   parameter int DW             = 8,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   output logic                 tx_start,
   output logic [DW-1:0]        tx_data,
   input  logic                 tx_busy,
   output logic [NREQ-1:0]      grant,
   output logic                 timeout_err
);

   // state     | meaning
   // S_IDLE    | no owner; arbitrate when tx_busy = 0
   // S_ISSUE   | owner granted; wait for its next byte, count stall cycles
   // S_SEND    | one-cycle tx_start with captured byte
   // S_WAIT_DONE | wait for tx_busy to fall, then release or fetch next byte
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SEND, S_WAIT_DONE} state_t;

   localparam int PTR_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   state_t             state, state_nxt;
   logic [NREQ-1:0]    grant_nxt;
   logic [PTR_W-1:0]   gnt_idx, gnt_idx_nxt;
   logic [CNT_W-1:0]   idle_cnt, idle_cnt_nxt;
   logic [DW-1:0]      tx_data_nxt;
   logic               last_flag, last_flag_nxt;
   logic               timeout_nxt;
   logic               sel_found;
   logic [PTR_W-1:0]   sel_idx;

`ifndef ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0]   last_ptr;
   logic               rel;

   assign rel = (state != S_IDLE) && (state_nxt == S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_ptr <= PTR_W'(NREQ-1);
      else if (rel)
         last_ptr <= gnt_idx;
   end
`endif

   // Downward scan so the last hit, i.e. the highest-priority candidate, wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
`ifdef ARB_FIXED_PRIO_EN
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'(i);
         end
      end
`else
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(last_ptr) + k) % NREQ]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'((int'(last_ptr) + k) % NREQ);
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         grant       <= '0;
         gnt_idx     <= '0;
         idle_cnt    <= '0;
         tx_data     <= '0;
         last_flag   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         gnt_idx     <= gnt_idx_nxt;
         idle_cnt    <= idle_cnt_nxt;
         tx_data     <= tx_data_nxt;
         last_flag   <= last_flag_nxt;
         timeout_err <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      gnt_idx_nxt   = gnt_idx;
      idle_cnt_nxt  = idle_cnt;
      tx_data_nxt   = tx_data;
      last_flag_nxt = last_flag;
      timeout_nxt   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!tx_busy && sel_found) begin
               grant_nxt    = NREQ'(1) << sel_idx;
               gnt_idx_nxt  = sel_idx;
               idle_cnt_nxt = '0;
               state_nxt    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (req_valid[gnt_idx]) begin
               tx_data_nxt   = req_data[int'(gnt_idx)*DW +: DW];
               last_flag_nxt = req_last[gnt_idx];
               idle_cnt_nxt  = '0;
               state_nxt     = S_SEND;
            end else if (idle_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
               timeout_nxt = 1'b1;
               grant_nxt   = '0;
               state_nxt   = S_IDLE;
            end else begin
               idle_cnt_nxt = idle_cnt + CNT_W'(1);
            end
         end
         S_SEND: state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_flag) begin
                  grant_nxt = '0;
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt = S_ISSUE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_ISSUE) ? (req_valid & grant) : '0;
      tx_start  = (state == S_SEND);
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NREQ byte-stream requesters, e.g. heartbeat status, key events and the loopback echo.
- Arbitration is round-robin at message granularity. A granted requester keeps the transmitter until it sends a byte flagged last, or until it stalls past a timeout.
- Sits between the requesters and the UART TX core; drives its start/data inputs and monitors its busy output.

Parameters:
- NREQ, 3, number of requesters (2..8).
- DW, 8, data byte width.
- TIMEOUT_CYCLES, 5000000, idle cycles a granted requester may stall before losing the grant (0.1 s at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NREQ  requester i has a byte on req_data.
- req_data  in  NREQ*DW  byte of requester i at [i*DW +: DW].
- req_last  in  NREQ  byte of requester i ends its message.
- req_ready  out  NREQ  byte of requester i accepted this cycle.
- tx_start  out  1  one-cycle start pulse to the UART TX.
- tx_data  out  DW  byte for the UART TX, valid while tx_start = 1.
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start and stays high until the frame ends.
- grant  out  NREQ  one-hot current owner; 0 when idle.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (rst = 0, asynchronous) values:
  - req_ready = 0, tx_start = 0, tx_data = 0, grant = 0, timeout_err = 0.
  - state = IDLE; pointer last = NREQ-1, so requester 0 wins first; idle counter = 0.
- State machine: IDLE, ISSUE, SEND, WAIT_DONE.
- IDLE:
  - If tx_busy = 0 and any req_valid, select the first requester with req_valid set, searching from last+1 upward and wrapping modulo NREQ.
  - Register grant one-hot; go to ISSUE. No byte is accepted in IDLE.
- ISSUE (owner g):
  - req_ready[g] = req_valid[g], combinational from state and grant; all other req_ready bits = 0.
  - If req_valid[g] = 1: capture req_data[g] into tx_data and req_last[g] into last_flag; clear the idle counter; go to SEND.
  - Else increment the idle counter. When it reaches TIMEOUT_CYCLES-1: pulse timeout_err, set last = g, clear grant, go to IDLE.
- SEND:
  - tx_start = 1 for exactly this cycle, tx_data stable; go to WAIT_DONE.
  - Latency: byte accepted at edge N, tx_start high in cycle N+1.
- WAIT_DONE:
  - tx_busy is not sampled until the cycle after SEND; stay while tx_busy = 1.
  - On tx_busy = 0: if last_flag, set last = g, clear grant, go to IDLE; else go to ISSUE keeping grant.
- Grant is never preempted by other requesters mid-message; only last or timeout releases it.
- Simultaneous requests in IDLE: round-robin order decides; the previous owner has lowest priority.
- tx_data holds its value outside SEND; only the value during tx_start is meaningful.
- Reset asserted mid-message: the in-flight byte is abandoned and all state returns to reset values immediately. The requester must re-send from its message start.
- The idle counter is clog2(TIMEOUT_CYCLES) bits wide and saturation cannot occur; it is cleared on every grant and every accepted byte.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: IDLE selects the lowest-index requester with req_valid set; pointer last is not used (may be removed). Timeout and last release still apply.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then requester 0 sends a 3-byte message 0x41, 0x42, 0x43 (last on 0x43), tx_busy model 10 cycles: three tx_start pulses carrying 0x41, 0x42, 0x43 in order; each tx_start one cycle after its req_ready; grant = 3'b001 throughout, then 0.
- Requesters 0 and 2 both valid in IDLE after reset, single-byte messages: requester 0 is served first, then requester 2. Repeat: requester 0 is not served twice in a row while 2 waits.
- Requester 1 sends byte 0x55 without last, then drops req_valid for TIMEOUT_CYCLES (set to 16): exactly one timeout_err pulse 16 cycles after entering ISSUE; grant returns to 0; a pending requester 2 is then granted.
- Requester 0 mid-message while requester 1 asserts valid: requester 1 receives no req_ready until requester 0's last byte completes and tx_busy falls.
- rst pulled low during WAIT_DONE: all outputs 0 immediately (asynchronous). After release, requester 0 wins the first arbitration.
- With ARB_FIXED_PRIO_EN defined, all three requesters continuously valid with single-byte messages: requester 0 is granted every time; requesters 1 and 2 are never served.
